// File: rtl/instr_fetch_pkg.sv
// Shared dimensions and types for the instruction fetch stage.
package const_dim;

  parameter int unsigned addr_width  = 32;
  parameter int unsigned data_width  = 32;
  parameter int unsigned instr_width = 32;
  parameter int unsigned instr_bytes = 4;

  typedef enum logic [0:0] {
    FETCH_REQ = 1'b0,
    WAIT_ACK  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_fifo.sv
// instr_fifo: small synchronous FIFO holding {pc, instr} entries.
// Registered storage; flush empties it and has priority over push/pop.
module instr_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [WIDTH-1:0]           o_dout,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only observed while the entry is occupied.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC holder, single-outstanding instruction memory reader and
// decode-side valid/ready buffer.
// Optional feature macro: FETCH_PERF_CNT_EN adds the stall_cycles counter/port.
module instr_fetch
  import const_dim::*;
#(
  parameter int unsigned           FIFO_DEPTH = 2,
  parameter logic [addr_width-1:0] RESET_PC   = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   mem_rd_req,
  output logic [addr_width-1:0]  mem_addr,
  input  logic                   mem_ack,
  input  logic [data_width-1:0]  mem_rd_data,
  input  logic                   redirect_valid,
  input  logic [addr_width-1:0]  redirect_pc,
  output logic                   instr_valid,
  output logic [instr_width-1:0] instr,
  output logic [addr_width-1:0]  instr_pc,
  input  logic                   instr_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]            stall_cycles
`endif
);

  localparam int unsigned ENTRY_W = addr_width + instr_width;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e          r_state;
  fetch_state_e          w_state_nxt;
  logic                  r_discard;
  logic                  w_discard_nxt;
  logic                  r_rst_done;
  logic [addr_width-1:0] r_fetch_pc;
  logic [addr_width-1:0] r_req_pc;
  logic                  w_issue;
  logic                  w_outstanding;
  logic                  w_has_room;

  logic                  w_fifo_push;
  logic                  w_fifo_pop;
  logic                  w_fifo_flush;
  logic [ENTRY_W-1:0]    w_fifo_din;
  logic [ENTRY_W-1:0]    w_fifo_dout;
  logic [CNT_W-1:0]      w_fifo_count;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;

  // Free slots = depth - occupancy - outstanding read, so an ack can never overflow.
  assign w_outstanding = (r_state == WAIT_ACK);
  assign w_has_room    = !w_fifo_full &&
                         (({1'b0, w_fifo_count} + (CNT_W+1)'(w_outstanding)) < (CNT_W+1)'(FIFO_DEPTH));

  assign w_fifo_din   = {r_req_pc, mem_rd_data[instr_width-1:0]};
  assign w_fifo_pop   = instr_valid && instr_ready;
  assign w_fifo_flush = redirect_valid;

  assign instr_valid = !w_fifo_empty;
  assign instr       = instr_valid ? w_fifo_dout[instr_width-1:0] : '0;
  assign instr_pc    = instr_valid ? w_fifo_dout[ENTRY_W-1 -: addr_width] : '0;
  assign mem_rd_req  = w_issue;
  assign mem_addr    = w_issue ? r_fetch_pc : '0;

  instr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_fifo_push),
    .i_din   (w_fifo_din),
    .i_pop   (w_fifo_pop),
    .i_flush (w_fifo_flush),
    .o_dout  (w_fifo_dout),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Fetch FSM state, discard flag and post-reset qualifier.
  // r_rst_done holds off the first request one cycle so every output is 0 during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FETCH_REQ;
      r_discard  <= 1'b0;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_discard  <= w_discard_nxt;
      r_rst_done <= 1'b1;
    end
  end

  // Next-state, request issue and FIFO push decisions; redirect has priority.
  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    w_issue       = 1'b0;
    w_fifo_push   = 1'b0;
    case (r_state)
      FETCH_REQ: begin
        if (!redirect_valid && r_rst_done && w_has_room) begin
          w_issue     = 1'b1;
          w_state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (mem_ack) begin
          w_fifo_push   = !r_discard && !redirect_valid;
          w_discard_nxt = 1'b0;
          w_state_nxt   = FETCH_REQ;
        end else if (redirect_valid) begin
          w_discard_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt   = FETCH_REQ;
        w_discard_nxt = 1'b0;
      end
    endcase
  end

  // Fetch PC and the PC of the outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
    end else if (w_issue) begin
      r_req_pc   <= r_fetch_pc;
      r_fetch_pc <= r_fetch_pc + addr_width'(instr_bytes);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  // Saturating count of cycles with nothing offered to decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (!instr_valid && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: memory model logs requests and returns
// addr ^ 32'hDEAD_0000; expected {pc,instr} pairs are queued by the stimulus
// and checked by an independent monitor on every decode handshake.
module tb_instr_fetch;
  import const_dim::*;

  localparam logic [31:0] K = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rd_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  int          pop_cyc[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_pop = 0;
  int          cyc   = 0;

  // memory model state
  bit          pend = 1'b0;
  logic [31:0] paddr = '0;
  int          left = 0;
  int          lat = 1;
  int          budget = 0;
  logic        m_ack = 1'b0;
  logic [31:0] m_data = '0;
  logic        i_ack = 1'b0;
  logic [31:0] i_data = '0;

  // monitor hold-tracking state
  logic        hold = 1'b0;
  logic        hredir = 1'b0;
  logic [31:0] hpc = '0;
  logic [31:0] hins = '0;

  assign mem_ack     = m_ack | i_ack;
  assign mem_rd_data = m_ack ? m_data : i_data;

  instr_fetch #(
    .FIFO_DEPTH (2),
    .RESET_PC   (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_rd_req     (mem_rd_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rd_data    (mem_rd_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endfunction

  function automatic void expect_pc(logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = pc ^ K;
    exp_q.push_back(e);
  endfunction

  // Memory model: ack 'lat' cycles after the request, limited by 'budget'.
  initial forever begin
    @(posedge clk); #1;
    m_ack = 1'b0;
    if (pend && budget > 0) begin
      if (left <= 0) begin
        m_ack  = 1'b1;
        m_data = paddr ^ K;
        pend   = 1'b0;
        budget--;
      end else begin
        left--;
      end
    end
    @(negedge clk);
    if (rst) begin
      pend = 1'b0;
    end else if (mem_rd_req) begin
      req_log.push_back(mem_addr);
      pend  = 1'b1;
      paddr = mem_addr;
      left  = lat - 1;
    end
  end

  // Monitor: stability while stalled, and scoreboard compare on each pop.
  initial forever begin
    @(negedge clk);
    if (!rst && hold && !hredir) begin
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_pc", instr_pc, hpc);
      check("hold_instr", instr, hins);
    end
    hold   = !rst && instr_valid && !instr_ready;
    hpc    = instr_pc;
    hins   = instr;
    hredir = redirect_valid;
    if (!rst && instr_valid && instr_ready) begin
      n_pop++;
      pop_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_instr: got pc %h instr %h, expected none", instr_pc, instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("instr_pc", instr_pc, e.pc);
        check("instr", instr, e.ins);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pops(int n, string nm);
    int t = 0;
    while (n_pop < n && t < 300) begin @(posedge clk); t++; end
    #1;
    check(nm, 32'(n_pop >= n), 32'd1);
  endtask

  task automatic wait_log(int n, string nm);
    int t = 0;
    while (req_log.size() < n && t < 300) begin @(posedge clk); t++; end
    #1;
    check(nm, 32'(req_log.size() >= n), 32'd1);
  endtask

  function automatic logic [31:0] log_at(int i);
    if (i < req_log.size()) return req_log[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; budget = 0; i_ack = 1'b0;
    @(negedge clk);
    check("rst_req", 32'(mem_rd_req), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_pc", instr_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_stall", stall_cycles, 32'd0);
`endif
    exp_q.delete(); req_log.delete(); pop_cyc.delete(); n_pop = 0;
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // 1: streaming, latency 1, ready high
    do_reset();
    lat = 1; budget = 3; instr_ready = 1'b1;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    wait_pops(3, "t1_pops");
    tick(4);
    check("t1_nreq", req_log.size(), 32'd4);
    check("t1_req0", log_at(0), 32'h0);
    check("t1_req1", log_at(1), 32'h4);
    check("t1_req2", log_at(2), 32'h8);
    check("t1_req3", log_at(3), 32'hC);
    check("t1_gap01", pop_cyc[1] - pop_cyc[0], 32'd2);
    check("t1_gap12", pop_cyc[2] - pop_cyc[1], 32'd2);
    check("t1_left", exp_q.size(), 32'd0);

    // 2: decode stalled for 10 cycles
    do_reset();
    lat = 1; budget = 3; instr_ready = 1'b0;
    tick(10);
    @(negedge clk);
    check("t2_nreq", req_log.size(), 32'd2);
    check("t2_req0", log_at(0), 32'h0);
    check("t2_req1", log_at(1), 32'h4);
    check("t2_noreq", 32'(mem_rd_req), 32'd0);
    check("t2_valid", 32'(instr_valid), 32'd1);
    check("t2_pc", instr_pc, 32'h0);
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
    tick(1);
    instr_ready = 1'b1;
    wait_pops(3, "t2_pops");
    check("t2_req2", log_at(2), 32'h8);
    tick(3);
    check("t2_left", exp_q.size(), 32'd0);

    // 3: redirect while waiting for PC 8, ack three cycles later
    do_reset();
    lat = 4; budget = 5; instr_ready = 1'b1;
    expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h100); expect_pc(32'h104);
    wait_log(3, "t3_req8");
    check("t3_req2", log_at(2), 32'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick(1);
    redirect_valid = 1'b0;
    wait_pops(4, "t3_pops");
    check("t3_req3", log_at(3), 32'h100);
    check("t3_left", exp_q.size(), 32'd0);

    // 4: redirect coinciding with ack and pop
    do_reset();
    lat = 1; budget = 4; instr_ready = 1'b0;
    expect_pc(32'h0); expect_pc(32'h40); expect_pc(32'h44);
    wait_log(2, "t4_req4");
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    check("t4_coincide", 32'(mem_ack && instr_valid), 32'd1);
    tick(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t4_flushed", 32'(instr_valid), 32'd0);
    wait_pops(3, "t4_pops");
    check("t4_req2", log_at(2), 32'h40);
    check("t4_left", exp_q.size(), 32'd0);

    // 5: reset mid-transaction with acks during and after reset
    do_reset();
    lat = 1; budget = 0; instr_ready = 1'b1;
    wait_log(1, "t5_req0");
    rst = 1'b1; i_ack = 1'b1; i_data = 32'hBAD0_BAD0;
    @(negedge clk);
    check("t5_rst_req", 32'(mem_rd_req), 32'd0);
    check("t5_rst_valid", 32'(instr_valid), 32'd0);
    req_log.delete();
    tick(1);
    i_ack = 1'b0;
    tick(1);
    rst = 1'b0; i_ack = 1'b1;
    tick(1);
    i_ack = 1'b0; budget = 1;
    expect_pc(32'h0);
    wait_pops(1, "t5_pops");
    check("t5_first_addr", log_at(0), 32'h0);
    tick(3);
    check("t5_left", exp_q.size(), 32'd0);

`ifdef FETCH_PERF_CNT_EN
    // 6: stall counter with memory silent
    do_reset();
    budget = 0; instr_ready = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("t6_stall", stall_cycles, 32'd20);
`endif

    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
